// File: rtl/vga_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_writer
// Description : Unpacks one DATA_W-bit word into NPIX = DATA_W/PIX_W pixels
//               and writes them, LSB pixel first, one per clock, to
//               consecutive framebuffer addresses starting at endereco_base.
//               Pixels whose address is past MEM_DEPTH-1 are not written
//               and raise err, which is reported alongside the done pulse.
//               Optional feature macro: VGA_PIXEL_WRITER_MASK_EN adds a
//               per-pixel write mask input (mask_in).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_writer #(
    parameter int DATA_W    = 32,
    parameter int PIX_W     = 1,
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_W-1:0]         dados_in,
    input  logic [ADDR_W-1:0]         endereco_base,
`ifdef VGA_PIXEL_WRITER_MASK_EN
    input  logic [DATA_W/PIX_W-1:0]   mask_in,
`endif
    output logic [PIX_W-1:0]          data,
    output logic [ADDR_W-1:0]         wraddress,
    output logic                      wren,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int NPIX  = DATA_W / PIX_W;
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NPIX - 1);
    // Highest legal address, held one bit wider than the address bus so the
    // base + index sum can be compared without losing the carry.
    localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W + 1)'(MEM_DEPTH - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   word_q,      word_d;      // shifts right one pixel per write
    logic [ADDR_W-1:0]   base_q,      base_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic                err_flag_q,  err_flag_d;  // sticky out-of-range flag
    logic [PIX_W-1:0]    data_q,      data_d;
    logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
    logic                wren_q,      wren_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;
`ifdef VGA_PIXEL_WRITER_MASK_EN
    logic [NPIX-1:0]     mask_q,      mask_d;      // shifts in step with word_q
`endif

    // ------------------------------------------------------------------------
    // Per-pixel helpers
    // ------------------------------------------------------------------------
    logic [ADDR_W:0]     pix_addr;
    logic                pix_in_range;
    logic                pix_enable;

    // Address of the current pixel, one bit wider to catch overflow past the
    // top of the address space, and its range test against the memory depth.
    always_comb begin
        pix_addr     = {1'b0, base_q} + (ADDR_W + 1)'(idx_q);
        pix_in_range = (pix_addr <= LAST_ADDR);
    end

    // The mask bit of the current pixel sits in bit 0 of the shifting mask.
`ifdef VGA_PIXEL_WRITER_MASK_EN
    assign pix_enable = mask_q[0];
`else
    assign pix_enable = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    // Computes every register's next value; outputs default to their idle
    // levels, while data and wraddress hold unless a pixel updates them.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        base_d      = base_q;
        idx_d       = idx_q;
        err_flag_d  = err_flag_q;
        data_d      = data_q;
        wraddress_d = wraddress_q;
        wren_d      = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef VGA_PIXEL_WRITER_MASK_EN
        mask_d      = mask_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    word_d     = dados_in;
                    base_d     = endereco_base;
                    idx_d      = '0;
                    err_flag_d = 1'b0;
`ifdef VGA_PIXEL_WRITER_MASK_EN
                    mask_d     = mask_in;
`endif
                    busy_d     = 1'b1;
                    state_d    = ST_WRITE;
                end
            end

            ST_WRITE: begin
                busy_d = 1'b1;
                // Current pixel is always in the low bits of the shifting word.
                data_d = word_q[PIX_W-1:0];
                word_d = word_q >> PIX_W;
`ifdef VGA_PIXEL_WRITER_MASK_EN
                mask_d = mask_q >> 1;
`endif
                if (pix_in_range) begin
                    wraddress_d = pix_addr[ADDR_W-1:0];
                    wren_d      = pix_enable;
                end else begin
                    // Out-of-range pixel: suppress the write, keep the last
                    // address on the bus, remember the error for done.
                    err_flag_d  = 1'b1;
                end

                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end

            ST_FINISH: begin
                // Single completion cycle; a start seen here is dropped.
                done_d  = 1'b1;
                err_d   = err_flag_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------------
    // State and registered outputs; reset clears everything and aborts any
    // transaction in flight, taking priority over start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            err_flag_q  <= 1'b0;
            data_q      <= '0;
            wraddress_q <= '0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef VGA_PIXEL_WRITER_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            err_flag_q  <= err_flag_d;
            data_q      <= data_d;
            wraddress_q <= wraddress_d;
            wren_q      <= wren_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef VGA_PIXEL_WRITER_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data      = data_q;
    assign wraddress = wraddress_q;
    assign wren      = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pixel_writer
// Description : Self-checking bench for vga_pixel_writer. Each transaction
//               is predicted from the word, the base address and the memory
//               depth: pixel i goes to base+i when that address exists,
//               done follows NPIX+1 edges after the accepting edge.
//               Exercises VGA_PIXEL_WRITER_MASK_EN when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_writer;

    localparam int DATA_W    = 32;
    localparam int PIX_W     = 1;
    localparam int ADDR_W    = 12;
    localparam int MEM_DEPTH = 4096;
    localparam int NPIX      = DATA_W / PIX_W;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic [DATA_W-1:0]   dados_in;
    logic [ADDR_W-1:0]   endereco_base;
`ifdef VGA_PIXEL_WRITER_MASK_EN
    logic [NPIX-1:0]     mask_in;
`endif
    logic [PIX_W-1:0]    data;
    logic [ADDR_W-1:0]   wraddress;
    logic                wren;
    logic                busy;
    logic                done;
    logic                err;

    int n_checks = 0;
    int n_fails  = 0;

    // Model copies of the two outputs that hold their value between writes.
    logic [PIX_W-1:0]    exp_data;
    logic [ADDR_W-1:0]   exp_addr;

    vga_pixel_writer #(
        .DATA_W    (DATA_W),
        .PIX_W     (PIX_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .dados_in      (dados_in),
        .endereco_base (endereco_base),
`ifdef VGA_PIXEL_WRITER_MASK_EN
        .mask_in       (mask_in),
`endif
        .data          (data),
        .wraddress     (wraddress),
        .wren          (wren),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx, input logic w, input logic b,
                                 input logic d, input logic e);
        check({ctx, " wren"},      32'(wren),      32'(w));
        check({ctx, " busy"},      32'(busy),      32'(b));
        check({ctx, " done"},      32'(done),      32'(d));
        check({ctx, " err"},       32'(err),       32'(e));
        check({ctx, " data"},      32'(data),      32'(exp_data));
        check({ctx, " wraddress"}, 32'(wraddress), 32'(exp_addr));
    endtask

    // Idle edges with start low: nothing moves, data/wraddress hold.
    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            reset = 1'b0;
            start = 1'b0;
            @(posedge clock);
            #1;
            check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One transaction. mode 0: single start pulse; 1: extra start pulses at
    // relative edges 5 and NPIX+1 (both must be ignored); 2: start held high
    // throughout; 3: reset (together with start) at relative edge 11.
    task automatic run_txn(input logic [DATA_W-1:0] word, input int base,
                           input logic [NPIX-1:0] mask, input int mode);
        bit aborted = 1'b0;
        for (int e = 0; e <= NPIX + 1; e++) begin
            @(negedge clock);
            if (e == 0) begin
                dados_in      = word;
                endereco_base = base[ADDR_W-1:0];
`ifdef VGA_PIXEL_WRITER_MASK_EN
                mask_in       = mask;
`endif
                start         = 1'b1;
            end else begin
                dados_in      = $urandom;
                endereco_base = ADDR_W'($urandom);
`ifdef VGA_PIXEL_WRITER_MASK_EN
                mask_in       = $urandom;
`endif
                start = (mode == 2) || (mode == 1 && (e == 5 || e == NPIX + 1));
            end
            if (mode == 3 && e == 11) begin
                reset = 1'b1;
                start = 1'b1;
            end
            @(posedge clock);
            #1;
            if (mode == 3 && e == 11) begin
                exp_data = '0;
                exp_addr = '0;
                check_outputs("abort", 1'b0, 1'b0, 1'b0, 1'b0);
                aborted = 1'b1;
                break;
            end
            if (e == 0) begin
                check_outputs("accept", 1'b0, 1'b1, 1'b0, 1'b0);
            end else if (e <= NPIX) begin
                int  i    = e - 1;
                int  a    = base + i;
                bit  en   = 1'b1;
                bit  w    = 1'b0;
`ifdef VGA_PIXEL_WRITER_MASK_EN
                en = mask[i];
`endif
                exp_data = PIX_W'(word >> (i * PIX_W));
                if (a <= MEM_DEPTH - 1) begin
                    exp_addr = ADDR_W'(a);
                    w        = en;
                end
                check_outputs("write", w, 1'b1, 1'b0, 1'b0);
            end else begin
                check_outputs("finish", 1'b0, 1'b0, 1'b1,
                              (base + NPIX - 1) > (MEM_DEPTH - 1));
            end
        end
        if (!aborted && mode != 2) begin
            @(negedge clock);
            start = 1'b0;
            @(posedge clock);
            #1;
            check_outputs("after done", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        dados_in      = '0;
        endereco_base = '0;
`ifdef VGA_PIXEL_WRITER_MASK_EN
        mask_in       = '0;
`endif
        exp_data      = '0;
        exp_addr      = '0;
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(5);

        // Basic write pattern, fully in range.
        run_txn(32'h0000_0005, 'h100, '1, 0);
        idle_cycles(2);

        // Half the pixels fall past the end of memory.
        run_txn($urandom, 'hFF0, '1, 0);
        idle_cycles(1);

        // Extra start pulses mid-write and during finish are ignored.
        run_txn($urandom, 'h200, '1, 1);
        idle_cycles(2);

        // Start held high: back-to-back with a one-cycle gap.
        run_txn($urandom, 'h300, '1, 2);
        run_txn($urandom, 'h400, '1, 0);
        idle_cycles(1);

        // Reset part way through aborts the transaction.
        run_txn($urandom, 'h500, '1, 3);
        idle_cycles(NPIX + 3);

`ifdef VGA_PIXEL_WRITER_MASK_EN
        run_txn($urandom, 'h600, 32'hFFFF_0000, 0);
        idle_cycles(1);
`endif

        // Randomized transactions, half of them near the top of memory.
        for (int t = 0; t < 8; t++) begin
            int              b;
            logic [NPIX-1:0] m;
            m = '1;
`ifdef VGA_PIXEL_WRITER_MASK_EN
            m = $urandom;
`endif
            if (t % 2 == 0) b = int'($urandom_range(MEM_DEPTH - NPIX - 8, MEM_DEPTH - 1));
            else            b = int'($urandom_range(0, MEM_DEPTH - 1));
            run_txn($urandom, b, m, 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
